mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port START_i  input  1  request a new operation.
REQ-005 SHALL have port OP_i  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port SRC_A_i  input  WORD_WIDTH  multiplicand/dividend, driven from register-file read port 1.
REQ-007 SHALL have port SRC_B_i  input  WORD_WIDTH  multiplier/divisor, driven from register-file read port 2.
REQ-008 SHALL have port BUSY_o  output  1  operation in progress.
REQ-009 SHALL have port DONE_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port HI_o  output  WORD_WIDTH  product upper half / remainder.
REQ-011 SHALL have port LO_o  output  WORD_WIDTH  product lower half / quotient.
REQ-012 SHALL have port DIV_BY_ZERO_o  output  1  divisor-zero flag, valid with DONE_o.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 SHALL, in IDLE with START_i=1, capture OP_i, SRC_A_i and SRC_B_i (magnitudes for signed ops), record result signs, clear the iteration counter and go to RUN.
REQ-015 SHALL ignore START_i in any state other than IDLE; captured operands stay unchanged.
REQ-016 SHALL in RUN perform one radix-2 step per cycle (shift-add multiply or restoring divide) for exactly WORD_WIDTH cycles, then go to FIX.
REQ-017 SHALL in FIX apply two's-complement sign correction for signed ops (product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign), then go to DONE.
REQ-018 SHALL in DONE load HI_o/LO_o, pulse DONE_o for exactly one cycle, and return to IDLE next cycle.
REQ-019 SHALL give fixed latency: START_i sampled at edge 0 -> DONE_o high during the cycle after edge WORD_WIDTH+2 (34 for WORD_WIDTH=32), independent of operand values.
REQ-020 SHALL assert BUSY_o in RUN, FIX and DONE, and deassert it in IDLE; a new START_i is accepted in the cycle DONE_o is low and BUSY_o is low.
REQ-021 SHALL hold HI_o, LO_o and DIV_BY_ZERO_o stable between DONE pulses.
REQ-022 SHALL, on divide with SRC_B_i=0, give LO_o = all ones, HI_o = dividend (unmodified), DIV_BY_ZERO_o=1, with normal latency.
REQ-023 SHALL, on DIV with dividend = most-negative value and divisor = -1, give LO_o = most-negative value, HI_o=0, DIV_BY_ZERO_o=0.
REQ-024 SHALL clear DIV_BY_ZERO_o on every DONE for multiply or non-zero divisor.

Reset
REQ-025 SHALL, when RST_N=0 at a rising edge, force state IDLE, BUSY_o=0, DONE_o=0, HI_o=0, LO_o=0, DIV_BY_ZERO_o=0, counter=0.
REQ-026 SHALL abort any in-flight operation on reset, with no DONE_o pulse for it.
REQ-027 SHALL ignore START_i in any cycle where RST_N=0.

Configuration
REQ-028 SHALL support macro MUL_DIV_SIGNED_EN: defined -> MULT/DIV signed per REQ-017/REQ-023; undefined -> OP_i[0] ignored, all ops unsigned, sign logic and FIX correction absent (FIX is still traversed, so latency is unchanged).

Structure
REQ-029 SHALL place the OP_i encoding constants, FSM state encoding and WORD_WIDTH default in shared package mul_div_pkg.
REQ-030 SHALL implement the per-cycle iteration datapath in sub-module mul_div_step (combinational; inputs: partial HI/LO, operand, op; outputs: next HI/LO).

Verification
REQ-031 SHALL test MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DONE at cycle 34.
REQ-032 SHALL test MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 SHALL test DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
REQ-034 SHALL test DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234, DIV_BY_ZERO_o=1; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-035 SHALL test START_i re-asserted at cycles 5 and 20 of a MULTU 3x5 -> ignored; result LO=15, single DONE pulse.
REQ-036 SHALL test RST_N=0 at cycle 10 of DIVU 100/7 -> outputs zero next cycle, no DONE; a following MULTU 2x2 -> LO=4.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared constants for the multiply/divide unit: default word width,
// OP_i encodings and FSM state encoding.
package mul_div_pkg;

    localparam int unsigned WORD_WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Multiply: right-shifting shift-add on {hi, lo}, with lo holding the multiplier.
// Divide:   restoring division, hi is the partial remainder, lo shifts the
//           dividend out and the quotient bits in.
module mul_div_step #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  is_div,
    input  logic [WORD_WIDTH-1:0] hi,
    input  logic [WORD_WIDTH-1:0] lo,
    input  logic [WORD_WIDTH-1:0] operand,
    output logic [WORD_WIDTH-1:0] hi_next,
    output logic [WORD_WIDTH-1:0] lo_next
);

    logic [WORD_WIDTH:0] sum;
    logic [WORD_WIDTH:0] shifted;
    logic [WORD_WIDTH:0] diff;

    // Next partial result for the selected operation
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            shifted = {hi, lo[WORD_WIDTH-1]};
            diff    = shifted - {1'b0, operand};
            // Partial remainder is always below the divisor, so a set MSB means borrow
            if (!diff[WORD_WIDTH]) begin
                hi_next = diff[WORD_WIDTH-1:0];
                lo_next = {lo[WORD_WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WORD_WIDTH-1:0];
                lo_next = {lo[WORD_WIDTH-2:0], 1'b0};
            end
        end else begin
            sum     = lo[0] ? ({1'b0, hi} + {1'b0, operand}) : {1'b0, hi};
            hi_next = sum[WORD_WIDTH:1];
            lo_next = {sum[0], lo[WORD_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one radix-2 step per cycle, fixed latency.
// Optional macro MUL_DIV_SIGNED_EN enables signed MULT/DIV; without it OP_i[0]
// is ignored and every operation is unsigned (FIX state still traversed).
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START_i,
    input  logic [1:0]            OP_i,
    input  logic [WORD_WIDTH-1:0] SRC_A_i,
    input  logic [WORD_WIDTH-1:0] SRC_B_i,
    output logic                  BUSY_o,
    output logic                  DONE_o,
    output logic [WORD_WIDTH-1:0] HI_o,
    output logic [WORD_WIDTH-1:0] LO_o,
    output logic                  DIV_BY_ZERO_o
);

    localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  dz_q, dz_d;
    logic [WORD_WIDTH-1:0] hi_q, hi_d;
    logic [WORD_WIDTH-1:0] lo_q, lo_d;
    logic [WORD_WIDTH-1:0] opnd_q, opnd_d;
    logic [WORD_WIDTH-1:0] hi_out_q, hi_out_d;
    logic [WORD_WIDTH-1:0] lo_out_q, lo_out_d;
    logic                  dz_out_q, dz_out_d;
    logic                  done_q, done_d;
    logic [WORD_WIDTH-1:0] step_hi;
    logic [WORD_WIDTH-1:0] step_lo;

`ifdef MUL_DIV_SIGNED_EN
    logic res_neg_q, res_neg_d;
    logic rem_neg_q, rem_neg_d;
    logic a_neg, b_neg;
`else
    logic unused_op_sign;
    assign unused_op_sign = OP_i[0];
`endif

    mul_div_step #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_step (
        .is_div  (is_div_q),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opnd_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        hi_out_d = hi_out_q;
        lo_out_d = lo_out_q;
        dz_out_d = dz_out_q;
        done_d   = 1'b0;
`ifdef MUL_DIV_SIGNED_EN
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // No new request in the cycle the completion pulse is shown
                if (START_i && !done_q) begin
                    is_div_d = OP_i[1];
                    dz_d     = OP_i[1] && (SRC_B_i == '0);
                    hi_d     = '0;
                    cnt_d    = '0;
`ifdef MUL_DIV_SIGNED_EN
                    a_neg     = OP_i[0] & SRC_A_i[WORD_WIDTH-1];
                    b_neg     = OP_i[0] & SRC_B_i[WORD_WIDTH-1];
                    lo_d      = a_neg ? -SRC_A_i : SRC_A_i;
                    opnd_d    = b_neg ? -SRC_B_i : SRC_B_i;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
`else
                    lo_d   = SRC_A_i;
                    opnd_d = SRC_B_i;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == LAST_STEP) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFix: begin
`ifdef MUL_DIV_SIGNED_EN
                if (is_div_q) begin
                    if (res_neg_q) lo_d = -lo_q;
                    if (rem_neg_q) hi_d = -hi_q;
                end else if (res_neg_q) begin
                    {hi_d, lo_d} = -{hi_q, lo_q};
                end
`endif
                // Divide by zero: remainder already equals the dividend, force quotient
                if (dz_q) lo_d = '1;
                state_d = StDone;
            end
            StDone: begin
                hi_out_d = hi_q;
                lo_out_d = lo_q;
                dz_out_d = dz_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            dz_out_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            hi_out_q <= hi_out_d;
            lo_out_q <= lo_out_d;
            dz_out_q <= dz_out_d;
            done_q   <= done_d;
`ifdef MUL_DIV_SIGNED_EN
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign BUSY_o        = (state_q != StIdle);
    assign DONE_o        = done_q;
    assign HI_o          = hi_out_q;
    assign LO_o          = lo_out_q;
    assign DIV_BY_ZERO_o = dz_out_q;

endmodule
